pattern_renderer: RTL

//  Parametrised, mode-selectable VGA test-pattern generator. Sits between the VGA sync

---
 rtl/pattern_renderer_pkg.sv | 18 +
 rtl/pattern_box_mover.sv | 89 ++++++++
 rtl/pattern_renderer.sv | 110 +++++++++++
 3 files changed

// File: rtl/pattern_renderer_pkg.sv
// Shared encodings for the VGA test-pattern renderer and its box mover.
package pattern_renderer_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_CHECK = 2'd1,
        MODE_BARS  = 2'd2,
        MODE_BOX   = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_e;

    localparam int CW_DEFAULT = 10;

endpackage

// File: rtl/pattern_box_mover.sv
// Bouncing-box position/direction state, advanced once per frame tick.
// Only instantiated when PATTERN_RENDERER_BOX_EN is defined.
module pattern_box_mover
    import pattern_renderer_pkg::*;
#(
    parameter int XW       = 11,
    parameter int YW       = 11,
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 600,
    parameter int BOX_SIZE = 64,
    parameter int SPEED    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_tick,
    output logic [XW-1:0] o_bx,
    output logic [YW-1:0] o_by
);

    // One extra bit so pos+SPEED never wraps before the limit compare.
    localparam logic [XW:0] X_LIM = (XW+1)'(H_ACTIVE - BOX_SIZE);
    localparam logic [YW:0] Y_LIM = (YW+1)'(V_ACTIVE - BOX_SIZE);
    localparam logic [XW:0] X_SPD = (XW+1)'(SPEED);
    localparam logic [YW:0] Y_SPD = (YW+1)'(SPEED);

    logic [XW-1:0] r_bx, w_bx_nxt;
    logic [YW-1:0] r_by, w_by_nxt;
    dir_e          r_dx, w_dx_nxt;
    dir_e          r_dy, w_dy_nxt;
    logic [XW:0]   w_x_up;
    logic [YW:0]   w_y_up;

    assign w_x_up = {1'b0, r_bx} + X_SPD;
    assign w_y_up = {1'b0, r_by} + Y_SPD;

    always_comb begin
        w_bx_nxt = r_bx;
        w_dx_nxt = r_dx;
        if (r_dx == DIR_POS) begin
            if (w_x_up > X_LIM) begin
                w_bx_nxt = X_LIM[XW-1:0];
                w_dx_nxt = DIR_NEG;
            end else begin
                w_bx_nxt = w_x_up[XW-1:0];
            end
        end else if ({1'b0, r_bx} < X_SPD) begin
            w_bx_nxt = '0;
            w_dx_nxt = DIR_POS;
        end else begin
            w_bx_nxt = r_bx - X_SPD[XW-1:0];
        end
    end

    always_comb begin
        w_by_nxt = r_by;
        w_dy_nxt = r_dy;
        if (r_dy == DIR_POS) begin
            if (w_y_up > Y_LIM) begin
                w_by_nxt = Y_LIM[YW-1:0];
                w_dy_nxt = DIR_NEG;
            end else begin
                w_by_nxt = w_y_up[YW-1:0];
            end
        end else if ({1'b0, r_by} < Y_SPD) begin
            w_by_nxt = '0;
            w_dy_nxt = DIR_POS;
        end else begin
            w_by_nxt = r_by - Y_SPD[YW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bx <= '0;
            r_by <= '0;
            r_dx <= DIR_POS;
            r_dy <= DIR_POS;
        end else if (i_tick) begin
            r_bx <= w_bx_nxt;
            r_by <= w_by_nxt;
            r_dx <= w_dx_nxt;
            r_dy <= w_dy_nxt;
        end
    end

    assign o_bx = r_bx;
    assign o_by = r_by;

endmodule

// File: rtl/pattern_renderer.sv
// Mode-selectable VGA test-pattern generator with one-clock pixel latency.
// Define PATTERN_RENDERER_BOX_EN to compile in the bouncing-box mode (else mode 3 = checker).
module pattern_renderer
    import pattern_renderer_pkg::*;
#(
    parameter int CW        = CW_DEFAULT,
    parameter int XW        = 11,
    parameter int YW        = 11,
    parameter int H_ACTIVE  = 800,
    parameter int V_ACTIVE  = 600,
    parameter int CELL_LOG2 = 4,
    parameter int BAR_LOG2  = 7,
    parameter int BOX_SIZE  = 64,
    parameter int SPEED     = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          candraw,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [1:0]    mode,
    input  logic [3*CW-1:0] fg_rgb,
    input  logic [3*CW-1:0] bg_rgb,
    output logic [CW-1:0] red,
    output logic [CW-1:0] green,
    output logic [CW-1:0] blue,
    output logic          vga_blank,
    output logic          frame_tick
);

    mode_e           r_mode;
    logic [3*CW-1:0] r_rgb;
    logic            r_blank;
    logic            r_frame_tick;
    logic [3*CW-1:0] w_rgb;
    logic            w_last;
    logic            w_check;
    logic [2:0]      w_bar_idx;

    assign w_last    = candraw && (x == XW'(H_ACTIVE - 1)) && (y == YW'(V_ACTIVE - 1));
    assign w_check   = x[CELL_LOG2] ^ y[CELL_LOG2];
    assign w_bar_idx = x[BAR_LOG2+2:BAR_LOG2];

`ifdef PATTERN_RENDERER_BOX_EN
    logic [XW-1:0] w_bx;
    logic [YW-1:0] w_by;
    logic          w_in_box;

    pattern_box_mover #(
        .XW       (XW),
        .YW       (YW),
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .BOX_SIZE (BOX_SIZE),
        .SPEED    (SPEED)
    ) u_box (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_tick (r_frame_tick),
        .o_bx   (w_bx),
        .o_by   (w_by)
    );

    assign w_in_box = ({1'b0, x} >= {1'b0, w_bx})
                   && ({1'b0, x} <  ({1'b0, w_bx} + (XW+1)'(BOX_SIZE)))
                   && ({1'b0, y} >= {1'b0, w_by})
                   && ({1'b0, y} <  ({1'b0, w_by} + (YW+1)'(BOX_SIZE)));
`endif

    always_comb begin
        w_rgb = bg_rgb;
        case (r_mode)
            MODE_SOLID: w_rgb = fg_rgb;
            MODE_CHECK: w_rgb = w_check ? fg_rgb : bg_rgb;
            MODE_BARS:  w_rgb = {{CW{w_bar_idx[2]}}, {CW{w_bar_idx[1]}}, {CW{w_bar_idx[0]}}};
`ifdef PATTERN_RENDERER_BOX_EN
            MODE_BOX:   w_rgb = w_in_box ? fg_rgb : bg_rgb;
`else
            MODE_BOX:   w_rgb = w_check ? fg_rgb : bg_rgb;
`endif
            default:    w_rgb = fg_rgb;
        endcase
    end

    // Mode only changes on the tick so a frame never mixes two patterns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb        <= '0;
            r_blank      <= 1'b0;
            r_frame_tick <= 1'b0;
            r_mode       <= MODE_SOLID;
        end else begin
            r_frame_tick <= w_last;
            r_blank      <= candraw;
            if (candraw) begin
                r_rgb <= w_rgb;
            end
            if (r_frame_tick) begin
                r_mode <= mode_e'(mode);
            end
        end
    end

    assign red        = r_rgb[3*CW-1:2*CW];
    assign green      = r_rgb[2*CW-1:CW];
    assign blue       = r_rgb[CW-1:0];
    assign vga_blank  = r_blank;
    assign frame_tick = r_frame_tick;

endmodule
